// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite responder with three read/write registers and a committed-write counter
// Ports: ACLK, ARESETn (synchronous, active-low); AW*/W*/B* write channels; AR*/R* read channels;
//        reg0_o..reg2_o live values of the read/write registers. Register 3 reads the write counter.
module axi_lite_reg_slave #(
    parameter logic [31:0] REG_RESET = 32'h0000_0000
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [3:0]  AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [3:0]  ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [31:0] reg0_o,
    output logic [31:0] reg1_o,
    output logic [31:0] reg2_o
);
    logic        r_aw_held, r_w_held, r_bvalid, r_rvalid;
    logic [1:0]  r_aw_sel, r_bresp;
    logic [31:0] r_wdata, r_rdata, r_count, r_reg0, r_reg1, r_reg2;
    logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    assign AWREADY  = !r_aw_held && !r_bvalid;
    assign WREADY   = !r_w_held && !r_bvalid;
    assign ARREADY  = !r_rvalid;
    assign w_aw_hs  = AWVALID && AWREADY;
    assign w_w_hs   = WVALID && WREADY;
    assign w_ar_hs  = ARVALID && ARREADY;
    assign w_commit = r_aw_held && r_w_held;
    assign w_wr_ok  = r_aw_sel != 2'd3;
    // Captured from the pre-edge register values, so a same-edge commit is not visible to the read
    assign w_rd_mux = ARADDR[3:2] == 2'd0 ? r_reg0 :
                      ARADDR[3:2] == 2'd1 ? r_reg1 :
                      ARADDR[3:2] == 2'd2 ? r_reg2 : r_count;
    assign w_unused = ^{AWADDR[1:0], ARADDR[1:0]};
    assign BVALID   = r_bvalid;
    assign BRESP    = r_bresp;
    assign RVALID   = r_rvalid;
    assign RDATA    = r_rdata;
    assign RRESP    = 2'b00;
    assign reg0_o   = r_reg0;
    assign reg1_o   = r_reg1;
    assign reg2_o   = r_reg2;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_sel  <= 2'd0;
            r_wdata   <= 32'd0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_count   <= 32'd0;
            r_reg0    <= REG_RESET;
            r_reg1    <= REG_RESET;
            r_reg2    <= REG_RESET;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_sel  <= AWADDR[3:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= WDATA;
            end
            // Both halves held: the ready terms are low, so no new handshake competes with this clear
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_ok ? 2'b00 : 2'b10;
                r_count   <= w_wr_ok ? r_count + 32'd1 : r_count;
                r_reg0    <= r_aw_sel == 2'd0 ? r_wdata : r_reg0;
                r_reg1    <= r_aw_sel == 2'd1 ? r_wdata : r_reg1;
                r_reg2    <= r_aw_sel == 2'd2 ? r_wdata : r_reg2;
            end else if (r_bvalid && BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
        end else if (r_rvalid && RREADY) begin
            r_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave: directed and randomized checks of axi_lite_reg_slave against a behavioural model
module tb_axi_lite_reg_slave;
    localparam logic [31:0] RR = 32'hA5A5_0000;

    logic        clk = 1'b0, rstn = 1'b0;
    logic [3:0]  awaddr = 4'd0, araddr = 4'd0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] wdata = 32'd0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, reg0, reg1, reg2;

    int n_pass = 0, n_tot = 0;
    logic cmp_en = 1'b0;

    axi_lite_reg_slave #(.REG_RESET(RR)) dut (
        .ACLK(clk), .ARESETn(rstn),
        .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready),
        .WDATA(wdata), .WVALID(wvalid), .WREADY(wready),
        .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
        .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready),
        .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
        .reg0_o(reg0), .reg1_o(reg1), .reg2_o(reg2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Model: bank m_reg[0..3] (3 = write counter), pending write address/data, outstanding responses
    logic [31:0] m_reg [4];
    logic        m_aw, m_w, m_b, m_r;
    logic [1:0]  m_asel, m_bresp;
    logic [31:0] m_wd, m_rd;
    logic        m_awrdy, m_wrdy, m_arrdy;
    assign m_awrdy = !m_aw && !m_b;
    assign m_wrdy  = !m_w && !m_b;
    assign m_arrdy = !m_r;

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 3; i++) m_reg[i] <= RR;
            m_reg[3] <= 32'd0;
            m_aw <= 1'b0; m_w <= 1'b0; m_b <= 1'b0; m_r <= 1'b0;
            m_asel <= 2'd0; m_bresp <= 2'b00; m_wd <= 32'd0; m_rd <= 32'd0;
        end else begin
            if (awvalid && m_awrdy) begin m_aw <= 1'b1; m_asel <= awaddr[3:2]; end
            if (wvalid && m_wrdy) begin m_w <= 1'b1; m_wd <= wdata; end
            if (m_aw && m_w) begin
                m_aw <= 1'b0; m_w <= 1'b0; m_b <= 1'b1;
                if (m_asel == 2'd3) m_bresp <= 2'b10;
                else begin
                    m_bresp <= 2'b00;
                    m_reg[m_asel] <= m_wd;
                    m_reg[3] <= m_reg[3] + 1;
                end
            end else if (m_b && bready) m_b <= 1'b0;
            if (arvalid && m_arrdy) begin m_r <= 1'b1; m_rd <= m_reg[araddr[3:2]]; end
            else if (m_r && rready) m_r <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("awready", awready, m_awrdy);
            chk("wready", wready, m_wrdy);
            chk("arready", arready, m_arrdy);
            chk("bvalid", bvalid, m_b);
            chk("bresp", bresp, m_bresp);
            chk("rvalid", rvalid, m_r);
            chk("rdata", rdata, m_rd);
            chk("rresp", rresp, 2'b00);
            chk("reg0", reg0, m_reg[0]);
            chk("reg1", reg1, m_reg[1]);
            chk("reg2", reg2, m_reg[2]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, output logic [1:0] resp);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 20 && !bvalid; i++) step();
        chk("wr_bvalid_seen", bvalid, 1'b1);
        resp = bresp;
        step();
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        araddr = a; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        for (int i = 0; i < 20 && !rvalid; i++) step();
        chk("rd_rvalid_seen", rvalid, 1'b1);
        d = rdata;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        step();
        cmp_en = 1'b1;
        step();
        rstn = 1'b1;
        chk("rst_reg0", reg0, RR);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_readys", {awready, wready, arready}, 3'b111);
        rd(4'hC, d); chk("rst_count", d, 32'd0);

        awaddr = 4'h4; wdata = 32'hDEAD_BEEF; awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr1_bvalid_early", bvalid, 1'b0);
        step();
        chk("wr1_bvalid", bvalid, 1'b1);
        chk("wr1_bresp", bresp, 2'b00);
        chk("wr1_reg1", reg1, 32'hDEAD_BEEF);
        step();
        rd(4'h4, d); chk("rd_reg1", d, 32'hDEAD_BEEF);
        rd(4'hC, d); chk("rd_count1", d, 32'd1);

        wdata = 32'h1234_5678; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("wfirst_wready", wready, 1'b0);
        chk("wfirst_awready", awready, 1'b1);
        step(); step();
        awaddr = 4'h8; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        chk("wfirst_bvalid_early", bvalid, 1'b0);
        step();
        chk("wfirst_bvalid", bvalid, 1'b1);
        chk("wfirst_reg2", reg2, 32'h1234_5678);
        step();

        wr(4'hC, 32'hFFFF_FFFF, r);
        chk("slverr_bresp", r, 2'b10);
        chk("slverr_reg0", reg0, RR);
        chk("slverr_reg1", reg1, 32'hDEAD_BEEF);
        chk("slverr_reg2", reg2, 32'h1234_5678);
        rd(4'hC, d); chk("slverr_count", d, 32'd2);

        bready = 1'b0;
        awaddr = 4'h0; wdata = 32'd0; awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", bvalid, 1'b1);
            chk("bp_bresp", bresp, 2'b00);
            chk("bp_readys", {awready, wready}, 2'b00);
            step();
        end
        bready = 1'b1;
        step();
        chk("bp_bvalid_clear", bvalid, 1'b0);
        rready = 1'b0;
        araddr = 4'h4; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_rvalid", rvalid, 1'b1);
            chk("bp_rdata", rdata, 32'hDEAD_BEEF);
            chk("bp_arready", arready, 1'b0);
            step();
        end
        rready = 1'b1;
        step();
        chk("bp_rvalid_clear", rvalid, 1'b0);

        awaddr = 4'h0; wdata = 32'h0000_0055; awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 4'h0; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("conc_rdata_old", rdata, 32'd0);
        chk("conc_reg0_new", reg0, 32'h55);
        chk("conc_bvalid", bvalid, 1'b1);
        step();
        rd(4'h0, d); chk("conc_rd_new", d, 32'h55);
        rd(4'hC, d); chk("conc_count", d, 32'd4);

        bready = 1'b0;
        awaddr = 4'h4; wdata = 32'h77; awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        chk("rstb_bvalid_before", bvalid, 1'b1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("rstb_bvalid", bvalid, 1'b0);
        chk("rstb_reg0", reg0, RR);
        bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstb_no_resp", bvalid, 1'b0);
        end
        rd(4'hC, d); chk("rstb_count", d, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            rstn    = $urandom_range(0, 299) != 0;
            awvalid = $urandom_range(0, 1) == 1;
            wvalid  = $urandom_range(0, 1) == 1;
            arvalid = $urandom_range(0, 1) == 1;
            bready  = $urandom_range(0, 3) != 0;
            rready  = $urandom_range(0, 3) != 0;
            awaddr  = 4'($urandom);
            araddr  = 4'($urandom);
            wdata   = $urandom;
            step();
        end
        rstn = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        step(); step(); step();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
